mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller at the far end of the load/store-buffer and instruction-fetch request interfaces. Accepts word/half/byte read and write requests and serializes them onto the 8-bit single-port RAM/IO bus one byte per cycle. Returns assembled data with one-cycle success pulses. Sits between the LSB and fetch unit above and the top-level RAM/IO port below.

## Interface
- No parameters. Constants come from the shared define file.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state freezes and mem_wr is forced 0
- jump_wrong  in  1  pipeline flush
- io_buffer_full  in  1  IO output buffer full; blocks acceptance of IO-address writes
- lsb_read_signal, lsb_write_signal  in  1 each  LSB request (level, held until success)
- requiring_length  in  2  byte count: REQUIRE8=0 (1 byte), REQUIRE16=1 (2 bytes), REQUIRE32=2 (4 bytes)
- to_mem_addr  in  32  LSB byte address
- to_mem_data  in  32  store data, little-endian, low bytes used
- mem_load_success  out  1  one-cycle pulse; from_mem_data valid the same cycle
- mem_store_success  out  1  one-cycle pulse
- from_mem_data  out  32  loaded data, zero-extended; the consumer applies sign extension
- if_read_signal  in  1  fetch request (level)
- if_addr  in  32  fetch address; always 4 bytes
- if_success  out  1  one-cycle pulse
- if_instr  out  32  fetched word, valid with if_success
- mem_din  in  8  RAM read data; valid the cycle after its address
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write

## Operation
- States: IDLE, IF_READ, LS_READ, LS_WRITE, DONE.
- IDLE arbitration:
  - An LSB request beats a fetch request.
  - lsb_write_signal beats lsb_read_signal if both are high.
  - If the chosen request is a write to 0x30000 or 0x30004 while io_buffer_full=1, nothing is accepted that cycle (fetch is also held) and the FSM stays in IDLE.
- On acceptance, latch address, length N (1, 2 or 4; fetch N=4), and write data. Clear byte counter k. Later changes on request inputs are ignored.
- LS_WRITE:
  - Each cycle drive mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - After byte N-1, go to DONE and pulse mem_store_success.
- IF_READ / LS_READ:
  - Drive mem_a=addr+k for k=0..N-1 on consecutive cycles, mem_wr=0.
  - Capture mem_din into byte k-1 of the shift register one cycle later.
  - After the last byte is captured, go to DONE and pulse the matching success signal with the assembled data. Upper bytes are zero.
- DONE: lasts one cycle; then IDLE. This gap lets the requester drop its level request before the next arbitration.
- jump_wrong while rdy=1:
  - IF_READ and LS_READ abort immediately: next state IDLE, no success pulse, counter cleared.
  - LS_WRITE always completes all bytes (the store is already committed), but mem_store_success is suppressed for that access.
  - IDLE does not accept a request in the flush cycle.
- rst overrides everything; mid-operation it aborts, including writes.
- Address arithmetic is 32-bit modulo, with no alignment check.

## Timing
- Reset values: state IDLE; mem_wr=0, mem_a=0, mem_dout=0; all success pulses 0; from_mem_data=0, if_instr=0; k=0.
- Cycle 0 = cycle in which the request is sampled high in IDLE.
- Write of N bytes: mem_wr=1 in cycles 1..N; success in cycle N+1 (DONE); IDLE in cycle N+2.
- Read of N bytes: addresses in cycles 1..N; data captured at the ends of cycles 2..N+1; success and data in cycle N+2; IDLE in cycle N+3.
- Word fetch: if_success in cycle 6.
- Success pulses last exactly one cycle. At most one success output is high in any cycle.
- rdy=0: counter, state and pulses hold; mem_wr=0. A pulse due in a frozen cycle is emitted when rdy returns.

## Structure
- The shared define file holds:
  - REQUIRE8/16/32 encodings
  - IO addresses 0x30000 and 0x30004
  - state encodings
  - ADDR/DATALEN widths
- No sub-module. Single FSM with a 3-bit byte counter and a 32-bit assembly/shift register; expect about 180 lines.

## Test plan
- LW at 0x100, RAM bytes 11,22,33,44 → mem_a 0x100..0x103 in cycles 1..4; mem_load_success in cycle 6 with from_mem_data=0x44332211.
- SH 0x0000ABCD to 0x200 → mem_wr=1 in cycles 1–2 writing CD@0x200 and AB@0x201; mem_store_success in cycle 3; byte 0x202 untouched.
- LB at 0x80 with RAM byte 0x80 → from_mem_data=0x00000080 in cycle 3.
- if_read_signal and lsb_read_signal raised together → LSB access first; fetch accepted in the first IDLE after LSB DONE; if_success 6 cycles later.
- jump_wrong in cycle 2 of a fetch → no if_success, IDLE in cycle 3. jump_wrong in cycle 2 of an SW → all 4 bytes written, no mem_store_success.
- SB to 0x30000 with io_buffer_full=1 for cycles 0–2 → no mem_wr until io_buffer_full drops; then a single write with mem_wr=1 one cycle after acceptance.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: request lengths, IO addresses,
// FSM state encoding and bus widths.
`timescale 1ns/1ps
package mem_ctrl_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;

   localparam logic [1:0] REQUIRE8  = 2'd0;
   localparam logic [1:0] REQUIRE16 = 2'd1;
   localparam logic [1:0] REQUIRE32 = 2'd2;

   localparam logic [ADDR_W-1:0] IO_ADDR_0 = 32'h0003_0000;
   localparam logic [ADDR_W-1:0] IO_ADDR_1 = 32'h0003_0004;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IF_READ  = 3'd1,
      LS_READ  = 3'd2,
      LS_WRITE = 3'd3,
      DONE     = 3'd4
   } state_t;

   function automatic logic [2:0] req_bytes(input logic [1:0] len);
      case (len)
         REQUIRE8:  return 3'd1;
         REQUIRE16: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

   function automatic logic is_io(input logic [ADDR_W-1:0] addr);
      return (addr == IO_ADDR_0) || (addr == IO_ADDR_1);
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serializes LSB and fetch requests onto the 8-bit RAM/IO bus one byte per
// cycle and returns assembled little-endian data with one-cycle success pulses.
`timescale 1ns/1ps
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              jump_wrong,
   input  logic              io_buffer_full,
   input  logic              lsb_read_signal,
   input  logic              lsb_write_signal,
   input  logic [1:0]        requiring_length,
   input  logic [ADDR_W-1:0] to_mem_addr,
   input  logic [DATA_W-1:0] to_mem_data,
   output logic              mem_load_success,
   output logic              mem_store_success,
   output logic [DATA_W-1:0] from_mem_data,
   input  logic              if_read_signal,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_success,
   output logic [DATA_W-1:0] if_instr,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   state_t            state_q, state_d;
   logic [2:0]        k_q, k_d;
   logic [2:0]        n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] captured;
   logic [DATA_W-1:0] from_d, instr_d;
   logic              suppress_q, suppress_d;
   logic              load_d, store_d, if_d;

   // Byte k-1 of the assembly register receives the RAM byte addressed last cycle.
   always_comb begin
      captured = data_q;
      case (k_q)
         3'd1:    captured[7:0]   = mem_din;
         3'd2:    captured[15:8]  = mem_din;
         3'd3:    captured[23:16] = mem_din;
         3'd4:    captured[31:24] = mem_din;
         default: captured        = data_q;
      endcase
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      k_d        = k_q;
      n_d        = n_q;
      addr_d     = addr_q;
      data_d     = data_q;
      suppress_d = suppress_q;
      load_d     = 1'b0;
      store_d    = 1'b0;
      if_d       = 1'b0;
      from_d     = from_mem_data;
      instr_d    = if_instr;

      case (state_q)
         IDLE: begin
            if (!jump_wrong) begin
               if (lsb_write_signal) begin
                  if (!(io_buffer_full && is_io(to_mem_addr))) begin
                     state_d    = LS_WRITE;
                     addr_d     = to_mem_addr;
                     n_d        = req_bytes(requiring_length);
                     data_d     = to_mem_data;
                     k_d        = 3'd0;
                     suppress_d = 1'b0;
                  end
               end else if (lsb_read_signal) begin
                  state_d = LS_READ;
                  addr_d  = to_mem_addr;
                  n_d     = req_bytes(requiring_length);
                  data_d  = '0;
                  k_d     = 3'd0;
               end else if (if_read_signal) begin
                  state_d = IF_READ;
                  addr_d  = if_addr;
                  n_d     = 3'd4;
                  data_d  = '0;
                  k_d     = 3'd0;
               end
            end
         end

         // A flushed store still drains every byte; only its success pulse is dropped.
         LS_WRITE: begin
            k_d = k_q + 3'd1;
            if (jump_wrong) suppress_d = 1'b1;
            if (k_q == n_q - 3'd1) begin
               state_d = DONE;
               k_d     = 3'd0;
               store_d = !(suppress_q || jump_wrong);
            end
         end

         IF_READ, LS_READ: begin
            if (jump_wrong) begin
               state_d = IDLE;
               k_d     = 3'd0;
            end else begin
               data_d = captured;
               if (k_q == n_q) begin
                  state_d = DONE;
                  k_d     = 3'd0;
                  if (state_q == IF_READ) begin
                     if_d    = 1'b1;
                     instr_d = captured;
                  end else begin
                     load_d = 1'b1;
                     from_d = captured;
                  end
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_a    = '0;
      mem_dout = 8'h00;
      mem_wr   = 1'b0;
      if (state_q == LS_WRITE) begin
         mem_a  = addr_q + ADDR_W'(k_q);
         mem_wr = rdy;
         case (k_q[1:0])
            2'd0: mem_dout = data_q[7:0];
            2'd1: mem_dout = data_q[15:8];
            2'd2: mem_dout = data_q[23:16];
            2'd3: mem_dout = data_q[31:24];
         endcase
      end else if ((state_q == IF_READ || state_q == LS_READ) && k_q < n_q) begin
         mem_a = addr_q + ADDR_W'(k_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         k_q               <= 3'd0;
         n_q               <= 3'd0;
         addr_q            <= '0;
         data_q            <= '0;
         suppress_q        <= 1'b0;
         mem_load_success  <= 1'b0;
         mem_store_success <= 1'b0;
         if_success        <= 1'b0;
         from_mem_data     <= '0;
         if_instr          <= '0;
      end else if (rdy) begin
         state_q           <= state_d;
         k_q               <= k_d;
         n_q               <= n_d;
         addr_q            <= addr_d;
         data_q            <= data_d;
         suppress_q        <= suppress_d;
         mem_load_success  <= load_d;
         mem_store_success <= store_d;
         if_success        <= if_d;
         from_mem_data     <= from_d;
         if_instr          <= instr_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table vectors, hand-written corner
// sequences and random transactions against a byte-array reference memory.
`timescale 1ns/1ps
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int K_LR = 0;
   localparam int K_LW = 1;
   localparam int K_IF = 2;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_wrong, io_buffer_full;
   logic        lsb_read_signal, lsb_write_signal, if_read_signal;
   logic [1:0]  requiring_length;
   logic [31:0] to_mem_addr, to_mem_data, if_addr;
   logic        mem_load_success, mem_store_success, if_success;
   logic [31:0] from_mem_data, if_instr, mem_a;
   logic [7:0]  mem_din, mem_dout;
   logic        mem_wr;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] ram [logic [31:0]];
   logic [7:0] gm  [logic [31:0]];

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
      .io_buffer_full(io_buffer_full),
      .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
      .requiring_length(requiring_length), .to_mem_addr(to_mem_addr),
      .to_mem_data(to_mem_data), .mem_load_success(mem_load_success),
      .mem_store_success(mem_store_success), .from_mem_data(from_mem_data),
      .if_read_signal(if_read_signal), .if_addr(if_addr),
      .if_success(if_success), .if_instr(if_instr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] gm_rd(input logic [31:0] a);
      return gm.exists(a) ? gm[a] : init_byte(a);
   endfunction

   // RAM: read data one cycle after its address, writes at the clock edge.
   always @(posedge clk) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
   end

   function automatic int nbytes(input int kind, input logic [1:0] len);
      if (kind == K_IF) return 4;
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   // Reference: byte-addressed memory, little-endian, zero-extended loads.
   function automatic void model(input int kind, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] exp_data, output int exp_lat);
      int n;
      n = nbytes(kind, len);
      exp_data = 32'h0;
      for (int i = 0; i < n; i++) begin
         if (kind == K_LW) gm[addr + 32'(i)] = wdata[8*i +: 8];
         else exp_data[8*i +: 8] = gm_rd(addr + 32'(i));
      end
      exp_lat = (kind == K_LW) ? n + 1 : n + 2;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_req();
      lsb_read_signal  = 1'b0;
      lsb_write_signal = 1'b0;
      if_read_signal   = 1'b0;
   endtask

   task automatic drive_req(input int kind, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata);
      clear_req();
      requiring_length = len;
      to_mem_data      = wdata;
      if (kind == K_IF) begin
         if_read_signal = 1'b1;
         if_addr        = addr;
      end else begin
         to_mem_addr = addr;
         if (kind == K_LW) lsb_write_signal = 1'b1;
         else              lsb_read_signal  = 1'b1;
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram[a] = d;
      gm[a]  = d;
   endtask

   task automatic run_txn(input string name, input int kind, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_lat);
      int n, got;
      logic [2:0]  pulses, exp_pulses;
      logic [31:0] data;
      n = nbytes(kind, len);
      exp_pulses = (kind == K_LR) ? 3'b100 : (kind == K_LW) ? 3'b010 : 3'b001;
      drive_req(kind, len, addr, wdata);
      got = -1;
      pulses = 3'b000;
      data = 32'h0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c <= n) begin
            check({name, ":mem_a"}, mem_a, addr + 32'(c - 1));
            check({name, ":mem_wr"}, 32'(mem_wr), 32'(kind == K_LW));
            if (kind == K_LW) check({name, ":mem_dout"}, 32'(mem_dout), 32'(wdata[8*(c-1) +: 8]));
         end
         if (mem_load_success || mem_store_success || if_success) begin
            got    = c;
            pulses = {mem_load_success, mem_store_success, if_success};
            data   = (kind == K_IF) ? if_instr : from_mem_data;
            break;
         end
      end
      clear_req();
      check({name, ":latency"}, 32'(got), 32'(exp_lat));
      check({name, ":pulses"}, 32'(pulses), 32'(exp_pulses));
      if (kind != K_LW) check({name, ":data"}, data, exp_data);
      step();
      check({name, ":pulse_len"}, 32'({mem_load_success, mem_store_success, if_success}), 32'h0);
   endtask

   typedef struct {
      string       name;
      int          kind;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e, e2;
      int lat, t_ld, t_if, cnt, wr_cnt;
      logic [31:0] d_ld, d_if;

      tbl[0] = '{"lw_0x100",  K_LR, REQUIRE32, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
      tbl[1] = '{"sh_0x200",  K_LW, REQUIRE16, 32'h0000_0200, 32'h0000_ABCD, 32'h0,         3};
      tbl[2] = '{"lb_0x80",   K_LR, REQUIRE8,  32'h0000_0080, 32'h0,         32'h0000_0080, 3};
      tbl[3] = '{"lh_0x200",  K_LR, REQUIRE16, 32'h0000_0200, 32'h0,         32'h0000_ABCD, 4};
      tbl[4] = '{"lb_0x202",  K_LR, REQUIRE8,  32'h0000_0202, 32'h0,         32'h0000_005A, 3};
      tbl[5] = '{"if_0x100",  K_IF, REQUIRE32, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
      tbl[6] = '{"sb_0x103",  K_LW, REQUIRE8,  32'h0000_0103, 32'h0000_00EE, 32'h0,         2};
      tbl[7] = '{"lw_0x100b", K_LR, REQUIRE32, 32'h0000_0100, 32'h0,         32'hEE33_2211, 6};
      tbl[8] = '{"sw_wrap",   K_LW, REQUIRE32, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0,         5};
      tbl[9] = '{"lh_wrap",   K_LR, REQUIRE16, 32'hFFFF_FFFF, 32'h0,         32'h0000_ADBE, 4};

      rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
      clear_req();
      requiring_length = 2'd0; to_mem_addr = 32'h0; to_mem_data = 32'h0; if_addr = 32'h0;
      repeat (3) step();
      check("reset:mem_wr", 32'(mem_wr), 32'h0);
      check("reset:mem_a", mem_a, 32'h0);
      check("reset:mem_dout", 32'(mem_dout), 32'h0);
      check("reset:pulses", 32'({mem_load_success, mem_store_success, if_success}), 32'h0);
      check("reset:from_mem_data", from_mem_data, 32'h0);
      check("reset:if_instr", if_instr, 32'h0);
      rst = 1'b0;
      step();

      preload(32'h100, 8'h11); preload(32'h101, 8'h22);
      preload(32'h102, 8'h33); preload(32'h103, 8'h44);
      preload(32'h80,  8'h80);

      for (int i = 0; i < 10; i++) begin
         model(tbl[i].kind, tbl[i].len, tbl[i].addr, tbl[i].wdata, e, lat);
         run_txn(tbl[i].name, tbl[i].kind, tbl[i].len, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_data, tbl[i].exp_lat);
      end

      // LSB read and fetch raised together: LSB first, fetch right after DONE.
      model(K_LR, REQUIRE8, 32'h80, 32'h0, e, lat);
      model(K_IF, REQUIRE32, 32'h100, 32'h0, e2, lat);
      lsb_read_signal = 1'b1; requiring_length = REQUIRE8; to_mem_addr = 32'h80;
      if_read_signal = 1'b1; if_addr = 32'h100;
      t_ld = -1; t_if = -1; d_ld = 32'h0; d_if = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 5) check("arb:fetch_addr", mem_a, 32'h100);
         if (mem_load_success) begin
            t_ld = c; d_ld = from_mem_data; lsb_read_signal = 1'b0;
         end
         if (if_success) begin
            t_if = c; d_if = if_instr; if_read_signal = 1'b0;
            break;
         end
      end
      clear_req();
      check("arb:load_cycle", 32'(t_ld), 32'd3);
      check("arb:load_data", d_ld, e);
      check("arb:fetch_cycle", 32'(t_if), 32'd10);
      check("arb:fetch_data", d_if, e2);
      step();

      // Write beats read.
      model(K_LW, REQUIRE8, 32'h300, 32'h77, e, lat);
      lsb_write_signal = 1'b1; lsb_read_signal = 1'b1;
      requiring_length = REQUIRE8; to_mem_addr = 32'h300; to_mem_data = 32'h77;
      step();
      check("wr_pri:mem_wr", 32'(mem_wr), 32'h1);
      check("wr_pri:mem_a", mem_a, 32'h300);
      step();
      check("wr_pri:pulses", 32'({mem_load_success, mem_store_success, if_success}), 32'b010);
      clear_req();
      step();

      // Flush in cycle 2 of a fetch.
      if_read_signal = 1'b1; if_addr = 32'h100;
      step();
      check("jf:addr_c1", mem_a, 32'h100);
      step();
      jump_wrong = 1'b1; if_read_signal = 1'b0;
      check("jf:addr_c2", mem_a, 32'h101);
      cnt = 0;
      for (int c = 3; c <= 10; c++) begin
         step();
         if (c == 3) begin
            jump_wrong = 1'b0;
            check("jf:idle_c3", mem_a, 32'h0);
         end
         if (if_success) cnt++;
      end
      check("jf:no_success", 32'(cnt), 32'h0);

      // Flush in cycle 2 of a word store.
      model(K_LW, REQUIRE32, 32'h400, 32'h0102_0304, e, lat);
      drive_req(K_LW, REQUIRE32, 32'h400, 32'h0102_0304);
      wr_cnt = 0; cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 2) begin jump_wrong = 1'b1; clear_req(); end
         if (c == 3) jump_wrong = 1'b0;
         wr_cnt += int'(mem_wr);
         cnt    += int'(mem_store_success);
      end
      check("jw:bytes_written", 32'(wr_cnt), 32'd4);
      check("jw:no_success", 32'(cnt), 32'h0);

      // IO write blocked by a full IO buffer; pending fetch must not slip in.
      model(K_LW, REQUIRE8, IO_ADDR_0, 32'h5C, e, lat);
      drive_req(K_LW, REQUIRE8, IO_ADDR_0, 32'h5C);
      io_buffer_full = 1'b1; if_read_signal = 1'b1; if_addr = 32'h500;
      wr_cnt = int'(mem_wr);
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 3) begin io_buffer_full = 1'b0; if_read_signal = 1'b0; end
         #1;
         check("io:held_addr", mem_a, 32'h0);
         wr_cnt += int'(mem_wr);
      end
      check("io:no_early_wr", 32'(wr_cnt), 32'h0);
      step();
      clear_req();
      check("io:mem_wr", 32'(mem_wr), 32'h1);
      check("io:mem_a", mem_a, IO_ADDR_0);
      check("io:mem_dout", 32'(mem_dout), 32'h5C);
      step();
      check("io:single_wr", 32'(mem_wr), 32'h0);
      check("io:success", 32'(mem_store_success), 32'h1);
      step();

      // rdy low for three cycles in the middle of a word store.
      model(K_LW, REQUIRE32, 32'h600, 32'hA1B2_C3D4, e, lat);
      drive_req(K_LW, REQUIRE32, 32'h600, 32'hA1B2_C3D4);
      t_ld = -1;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c == 2) rdy = 1'b0;
         if (c == 5) rdy = 1'b1;
         #1;
         if (c >= 2 && c <= 4) begin
            check("rdy:wr_forced_low", 32'(mem_wr), 32'h0);
            check("rdy:addr_frozen", mem_a, 32'h601);
         end
         if (mem_store_success) begin t_ld = c; break; end
      end
      clear_req();
      check("rdy:success_cycle", 32'(t_ld), 32'd8);
      step();

      // Reset in the middle of a store aborts it.
      drive_req(K_LW, REQUIRE32, 32'h700, 32'h5566_7788);
      step();
      step();
      rst = 1'b1; clear_req();
      step();
      rst = 1'b0;
      check("rst_mid:mem_wr", 32'(mem_wr), 32'h0);
      check("rst_mid:mem_a", mem_a, 32'h0);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         cnt += int'(mem_store_success);
      end
      check("rst_mid:no_success", 32'(cnt), 32'h0);

      // Random traffic against the reference memory.
      for (int i = 0; i < 40; i++) begin
         int kind;
         logic [1:0] len;
         logic [31:0] addr, wdata;
         kind  = int'($urandom_range(0, 2));
         len   = 2'($urandom_range(0, 2));
         addr  = 32'h1000 + 32'($urandom_range(0, 31));
         wdata = $urandom;
         model(kind, len, addr, wdata, e, lat);
         run_txn($sformatf("rnd%0d", i), kind, len, addr, wdata, e, lat);
         repeat ($urandom_range(0, 2)) step();
      end

      foreach (gm[a]) check($sformatf("ram[%0h]", a), 32'(ram_rd(a)), 32'(gm[a]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
